alu_issue_seq: RTL and testbench

Instruction issue and writeback stage that sits directly upstream of the 8-bit ALU card. It accepts one instruction at a time over a valid/ready handshake and reads operands from a 4x8 register file. It drives the card's a/b/op/csel/cclear inputs, holds them while the result settles, then writes res back into the register file and latches the card's sign/zero flags.

---
 rtl/alu_issue_seq.sv | 168 ++++++++++++++++
 tb/tb_alu_issue_seq.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_seq.sv
// Issue/writeback stage for the 8-bit ALU card: it reads operands from a 4-entry register file,
// holds them on the card for EXEC_CYCLES, then writes the result back and latches the flags.
module alu_issue_seq #(
    parameter int EXEC_CYCLES = 1,
    parameter int DW          = 8
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [2:0]    instr_op,
    input  logic [1:0]    instr_srca,
    input  logic [1:0]    instr_srcb,
    input  logic          instr_useimm,
    input  logic [DW-1:0] instr_imm,
    input  logic [1:0]    instr_dst,
    input  logic          instr_nowb,
    input  logic          instr_chain,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [2:0]    alu_op,
    output logic          alu_csel,
    output logic          alu_cclear,
    input  logic [DW-1:0] alu_res,
    input  logic          alu_sign,
    input  logic          alu_zero,
    output logic          wb_valid,
    output logic [1:0]    wb_dst,
    output logic [DW-1:0] wb_data,
    output logic          flag_sign,
    output logic          flag_zero,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [DW-1:0] rf_q [4];
    logic [DW-1:0] rf_d [4];
    logic [DW-1:0] alu_a_q, alu_a_d;
    logic [DW-1:0] alu_b_q, alu_b_d;
    logic [2:0]    alu_op_q, alu_op_d;
    logic          alu_csel_q, alu_csel_d;
    logic          alu_cclear_q, alu_cclear_d;
    logic [1:0]    dst_q, dst_d;
    logic          nowb_q, nowb_d;
    logic [DW-1:0] res_q, res_d;
    logic          wb_valid_q, wb_valid_d;
    logic [1:0]    wb_dst_q, wb_dst_d;
    logic [DW-1:0] wb_data_q, wb_data_d;
    logic          flag_sign_q, flag_sign_d;
    logic          flag_zero_q, flag_zero_d;

    // Handshake: an instruction transfers on a rising edge where instr_valid and instr_ready are
    // both high; ready is only offered in IDLE outside reset, and valid is ignored otherwise.
    assign instr_ready = (state_q == IDLE) && !clear;
    assign busy        = (state_q != IDLE);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rf_d         = rf_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        alu_csel_d   = alu_csel_q;
        alu_cclear_d = 1'b0;
        dst_d        = dst_q;
        nowb_d       = nowb_q;
        res_d        = res_q;
        wb_valid_d   = 1'b0;
        wb_dst_d     = wb_dst_q;
        wb_data_d    = wb_data_q;
        flag_sign_d  = flag_sign_q;
        flag_zero_d  = flag_zero_q;
        case (state_q)
            IDLE: begin
                if (instr_valid && instr_ready) begin
                    alu_a_d      = rf_q[instr_srca];
                    alu_b_d      = instr_useimm ? instr_imm : rf_q[instr_srcb];
                    alu_op_d     = instr_op;
                    alu_csel_d   = instr_chain;
                    alu_cclear_d = !instr_chain;
                    dst_d        = instr_dst;
                    nowb_d       = instr_nowb;
                    cnt_d        = 4'(EXEC_CYCLES - 1);
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == 4'd0) begin
                    res_d   = alu_res;
                    state_d = WB;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WB: begin
                // The card's flags were registered one edge after the operands, so they are settled here.
                if (!nowb_q) begin
                    rf_d[dst_q] = res_q;
                end
                wb_valid_d  = 1'b1;
                wb_dst_d    = dst_q;
                wb_data_d   = res_q;
                flag_sign_d = alu_sign;
                flag_zero_d = alu_zero;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rf_q         <= '{default: '0};
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            alu_csel_q   <= 1'b0;
            alu_cclear_q <= 1'b0;
            dst_q        <= '0;
            nowb_q       <= 1'b0;
            res_q        <= '0;
            wb_valid_q   <= 1'b0;
            wb_dst_q     <= '0;
            wb_data_q    <= '0;
            flag_sign_q  <= 1'b0;
            flag_zero_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rf_q         <= rf_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            alu_csel_q   <= alu_csel_d;
            alu_cclear_q <= alu_cclear_d;
            dst_q        <= dst_d;
            nowb_q       <= nowb_d;
            res_q        <= res_d;
            wb_valid_q   <= wb_valid_d;
            wb_dst_q     <= wb_dst_d;
            wb_data_q    <= wb_data_d;
            flag_sign_q  <= flag_sign_d;
            flag_zero_q  <= flag_zero_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign alu_csel   = alu_csel_q;
    assign alu_cclear = alu_cclear_q;
    assign wb_valid   = wb_valid_q;
    assign wb_dst     = wb_dst_q;
    assign wb_data    = wb_data_q;
    assign flag_sign  = flag_sign_q;
    assign flag_zero  = flag_zero_q;

endmodule

// File: tb/tb_alu_issue_seq.sv
// Bench for alu_issue_seq: a behavioural ALU card, a vector table, hand sequences for
// abort/burst, and a writeback scoreboard.
module tb_alu_issue_seq;
  localparam int DW = 8;
  localparam int E  = 3;

  typedef struct {
    logic [2:0]    op;
    logic [1:0]    srca;
    logic [1:0]    srcb;
    logic          useimm;
    logic [DW-1:0] imm;
    logic [1:0]    dst;
    logic          nowb;
    logic          chain;
    logic [DW-1:0] exp_data;
    logic          exp_sign;
    logic          exp_zero;
  } vec_t;

  logic          clk = 1'b0;
  logic          clear;
  logic          instr_valid;
  logic          instr_ready;
  logic [2:0]    instr_op;
  logic [1:0]    instr_srca, instr_srcb, instr_dst;
  logic          instr_useimm, instr_nowb, instr_chain;
  logic [DW-1:0] instr_imm;
  logic [DW-1:0] alu_a, alu_b, alu_res, wb_data;
  logic [2:0]    alu_op;
  logic          alu_csel, alu_cclear, alu_sign, alu_zero;
  logic          wb_valid, flag_sign, flag_zero, busy;
  logic [1:0]    wb_dst;

  logic [DW+3:0] exp_q[$];
  int            acc_q[$];
  logic [DW-1:0] rf_m [4];
  int            n_vec = 0;
  int            n_err = 0;
  int            cyc = 0;
  int            cclear_cnt = 0;

  alu_issue_seq #(.EXEC_CYCLES(E), .DW(DW)) dut (
    .clk(clk), .clear(clear),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_srca(instr_srca), .instr_srcb(instr_srcb),
    .instr_useimm(instr_useimm), .instr_imm(instr_imm), .instr_dst(instr_dst),
    .instr_nowb(instr_nowb), .instr_chain(instr_chain),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_csel(alu_csel),
    .alu_cclear(alu_cclear), .alu_res(alu_res), .alu_sign(alu_sign), .alu_zero(alu_zero),
    .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_data(wb_data),
    .flag_sign(flag_sign), .flag_zero(flag_zero), .busy(busy)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always_ff @(posedge clk) cyc <= cyc + 1;

  // ALU card model: 0 add, 1 sub (carry = borrow), 2 and, 3 or, 4 xor, 5 pass b, 6 not a, 7 pass a
  function automatic logic [DW:0] alu_ref(input logic [2:0] op, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b, input logic cin);
    case (op)
      3'd0:    return {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, cin};
      3'd1:    return {1'b0, a} - {1'b0, b} - {{DW{1'b0}}, cin};
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a | b};
      3'd4:    return {1'b0, a ^ b};
      3'd5:    return {1'b0, b};
      3'd6:    return {1'b0, ~a};
      default: return {1'b0, a};
    endcase
  endfunction

  logic          carry_q, sign_q, zero_q;
  logic [DW:0]   full;
  always_comb full = alu_ref(alu_op, alu_a, alu_b, alu_csel ? carry_q : 1'b0);
  assign alu_res  = full[DW-1:0];
  assign alu_sign = sign_q;
  assign alu_zero = zero_q;
  always_ff @(posedge clk) begin
    if (clear) begin
      carry_q <= 1'b0;
      sign_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      sign_q <= full[DW-1];
      zero_q <= (full[DW-1:0] == '0);
      if (alu_cclear) carry_q <= 1'b0;
      else if (wb_valid) carry_q <= full[DW];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [1:0] sa, input logic [1:0] sb,
                              input logic ui, input logic [DW-1:0] imm, input logic [1:0] dst,
                              input logic nowb, input logic chain, input logic [DW-1:0] ed,
                              input logic es, input logic ez);
    vec_t v;
    v.op = op; v.srca = sa; v.srcb = sb; v.useimm = ui; v.imm = imm; v.dst = dst;
    v.nowb = nowb; v.chain = chain; v.exp_data = ed; v.exp_sign = es; v.exp_zero = ez;
    return v;
  endfunction

  task automatic drive_fields(input vec_t v);
    instr_op = v.op; instr_srca = v.srca; instr_srcb = v.srcb; instr_useimm = v.useimm;
    instr_imm = v.imm; instr_dst = v.dst; instr_nowb = v.nowb; instr_chain = v.chain;
  endtask

  // Called at the negedge before the accepting edge.
  task automatic push_exp(input vec_t v);
    exp_q.push_back({v.dst, v.exp_sign, v.exp_zero, v.exp_data});
    acc_q.push_back(cyc + 1);
    if (!v.nowb) rf_m[v.dst] = v.exp_data;
  endtask

  task automatic issue(input vec_t v, input bit push);
    int guard = 0;
    @(negedge clk);
    drive_fields(v);
    instr_valid = 1'b1;
    while (!instr_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!instr_ready) begin
      check("issue_timeout", 64'd0, 64'd1);
    end else if (push) begin
      push_exp(v);
    end
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    check("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  // scoreboard: every wb_valid pops one expectation, including its latency
  always @(negedge clk) begin
    logic [DW+3:0] e;
    int a;
    if (alu_cclear) cclear_cnt++;
    if (wb_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_wb", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        check("wb_dst", 64'(wb_dst), 64'(e[DW+3:DW+2]));
        check("wb_data", 64'(wb_data), 64'(e[DW-1:0]));
        check("flag_sign", 64'(flag_sign), 64'(e[DW+1]));
        check("flag_zero", 64'(flag_zero), 64'(e[DW]));
        check("wb_latency", 64'(cyc - a), 64'(E + 1));
      end
    end
  end

  function automatic vec_t rand_vec();
    vec_t v;
    logic [DW-1:0] b;
    v.op = 3'(2 + $urandom_range(0, 3));
    v.srca = 2'($urandom_range(0, 3));
    v.srcb = 2'($urandom_range(0, 3));
    v.useimm = 1'($urandom_range(0, 1));
    v.imm = DW'($urandom_range(0, 255));
    v.dst = 2'($urandom_range(0, 3));
    v.nowb = 1'($urandom_range(0, 1));
    v.chain = 1'($urandom_range(0, 1));
    b = v.useimm ? v.imm : rf_m[v.srcb];
    v.exp_data = alu_ref(v.op, rf_m[v.srca], b, 1'b0)  [DW-1:0];
    v.exp_sign = v.exp_data[DW-1];
    v.exp_zero = (v.exp_data == '0);
    return v;
  endfunction

  initial begin
    vec_t tbl [12];
    vec_t cur;
    int   c0;
    int   prev_acc;

    tbl[0]  = mk(3'd0, 2'd0, 2'd0, 1'b1, 8'h3C, 2'd1, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0);
    tbl[1]  = mk(3'd4, 2'd1, 2'd0, 1'b1, 8'h3C, 2'd2, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    tbl[2]  = mk(3'd0, 2'd0, 2'd0, 1'b1, 8'hFF, 2'd0, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0);
    tbl[3]  = mk(3'd0, 2'd0, 2'd0, 1'b1, 8'h01, 2'd3, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    tbl[4]  = mk(3'd0, 2'd2, 2'd0, 1'b1, 8'h00, 2'd2, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0);
    tbl[5]  = mk(3'd1, 2'd1, 2'd1, 1'b0, 8'h00, 2'd1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    tbl[6]  = mk(3'd0, 2'd1, 2'd0, 1'b1, 8'h00, 2'd3, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0);
    tbl[7]  = mk(3'd3, 2'd2, 2'd1, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 8'h3D, 1'b0, 1'b0);
    tbl[8]  = mk(3'd2, 2'd0, 2'd0, 1'b1, 8'h0F, 2'd1, 1'b0, 1'b0, 8'h0D, 1'b0, 1'b0);
    tbl[9]  = mk(3'd5, 2'd3, 2'd0, 1'b1, 8'h80, 2'd2, 1'b0, 1'b0, 8'h80, 1'b1, 1'b0);
    tbl[10] = mk(3'd1, 2'd2, 2'd0, 1'b1, 8'h81, 2'd3, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0);
    tbl[11] = mk(3'd1, 2'd1, 2'd0, 1'b1, 8'h00, 2'd0, 1'b0, 1'b1, 8'h0C, 1'b0, 1'b0);

    // reset
    clear = 1'b1;
    instr_valid = 1'b0;
    drive_fields(tbl[0]);
    for (int i = 0; i < 4; i++) rf_m[i] = '0;
    repeat (2) @(negedge clk);
    check("ready_in_reset", 64'(instr_ready), 64'd0);
    check("outputs_in_reset",
          64'({alu_a, alu_b, alu_op, alu_csel, alu_cclear, wb_valid, wb_dst, wb_data,
               flag_sign, flag_zero, busy}), 64'd0);
    clear = 1'b0;
    #1;
    check("ready_after_reset", 64'(instr_ready), 64'd1);

    // table vectors, one at a time
    for (int i = 0; i < 12; i++) begin
      c0 = cclear_cnt;
      issue(tbl[i], 1'b1);
      drain();
      check($sformatf("cclear_pulses_v%0d", i), 64'(cclear_cnt - c0), 64'(!tbl[i].chain));
    end

    // valid held high with a fresh instruction after each accept
    prev_acc = -1;
    cur = rand_vec();
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      drive_fields(cur);
      instr_valid = 1'b1;
      if (instr_ready) begin
        push_exp(cur);
        if (prev_acc >= 0) check("issue_interval", 64'(cyc + 1 - prev_acc), 64'(E + 2));
        prev_acc = cyc + 1;
        cur = rand_vec();
      end else begin
        check("busy_while_not_ready", 64'(busy), 64'd1);
      end
    end
    @(negedge clk);
    instr_valid = 1'b0;
    drain();

    // clear during EXEC aborts the instruction
    issue(mk(3'd0, 2'd0, 2'd0, 1'b1, 8'h55, 2'd1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0), 1'b0);
    check("busy_in_exec", 64'(busy), 64'd1);
    clear = 1'b1;
    @(negedge clk);
    check("ready_during_clear", 64'(instr_ready), 64'd0);
    check("outputs_after_abort",
          64'({alu_a, alu_b, alu_op, alu_csel, alu_cclear, wb_valid, wb_dst, wb_data,
               flag_sign, flag_zero, busy}), 64'd0);
    clear = 1'b0;
    #1;
    check("ready_after_clear", 64'(instr_ready), 64'd1);
    for (int i = 0; i < 4; i++) rf_m[i] = '0;
    repeat (E + 3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      issue(mk(3'd0, 2'(i), 2'd0, 1'b1, 8'h00, 2'(i), 1'b1, 1'b0, 8'h00, 1'b0, 1'b1), 1'b1);
      drain();
    end

    repeat (3) @(negedge clk);
    check("queue_empty_at_end", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
